// File: rtl/intc_pkg.sv
// Shared types and helpers for the int_ctrl interrupt controller.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2,
        HOLD = 2'd3
    } intc_state_e;

    localparam int NSRC_DEF = 4;

    // One-hot of the lowest set bit; bit 0 is the highest priority.
    function automatic logic [31:0] prio_onehot(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/intc_edge_sync.sv
// Single-bit synchroniser with a history flop, producing a one-cycle rising-edge strobe.
module intc_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    // Synchroniser shift chain and edge history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise = sync_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller driving the CPU Ireq/gntInt/Iack handshake.
// Optional: define INTC_REARB_EN to preempt a pending request with a higher-priority source.
module int_ctrl
    import intc_pkg::*;
#(
    parameter int NSRC        = NSRC_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NSRC-1:0] int_src_i,
    input  logic [31:0]     int_en_i,
    input  logic            Iack,
    output logic            Ireq,
    output logic [NSRC-1:0] gntInt,
    output logic [NSRC-1:0] pending_o,
    output logic [1:0]      state_o
);

    localparam int                CNT_W     = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [NSRC-1:0]   ZERO_SRC  = {NSRC{1'b0}};

    logic [NSRC-1:0]  edge_s;
    logic [NSRC-1:0]  pending_r;
    logic [NSRC-1:0]  eligible_s;
    logic [NSRC-1:0]  clr_s;
    logic [NSRC-1:0]  pick_s;
    logic [31:0]      pick_full_s;
    logic [NSRC-1:0]  gnt_r;
    logic             ireq_r;
    intc_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             unused_s;

    for (genvar i = 0; i < NSRC; i++) begin : g_sync
        intc_edge_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .reset_n  (reset_n),
            .async_in (int_src_i[i]),
            .rise     (edge_s[i])
        );
    end

    // Eligibility, priority pick and acknowledge-driven clear mask.
    always_comb begin
        eligible_s  = pending_r & int_en_i[NSRC-1:0];
        pick_full_s = prio_onehot(32'(eligible_s));
        pick_s      = pick_full_s[NSRC-1:0];
        if (state_r == REQ && Iack) begin
            clr_s = gnt_r;
        end else begin
            clr_s = ZERO_SRC;
        end
    end

    // Pending register: a new edge beats a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= ZERO_SRC;
        end else begin
            pending_r <= (pending_r & ~clr_s) | edge_s;
        end
    end

    // Handshake FSM with registered request, grant and hold counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            ireq_r  <= 1'b0;
            gnt_r   <= ZERO_SRC;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (eligible_s != ZERO_SRC) begin
                        ireq_r  <= 1'b1;
                        gnt_r   <= pick_s;
                        state_r <= REQ;
                    end
                end
                REQ: begin
                    if (Iack) begin
                        ireq_r  <= 1'b0;
                        gnt_r   <= ZERO_SRC;
                        state_r <= SERV;
                    end else if ((gnt_r & int_en_i[NSRC-1:0]) == ZERO_SRC) begin
                        ireq_r  <= 1'b0;
                        gnt_r   <= ZERO_SRC;
                        state_r <= IDLE;
                    end
`ifdef INTC_REARB_EN
                    // Both one-hot: a numerically smaller pick is a lower index, i.e. higher priority.
                    else if (pick_s != ZERO_SRC && pick_s < gnt_r) begin
                        ireq_r  <= 1'b0;
                        gnt_r   <= ZERO_SRC;
                        state_r <= IDLE;
                    end
`endif
                end
                SERV: begin
                    if (!Iack) begin
                        cnt_r   <= HOLD_LOAD;
                        state_r <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ireq_r  <= 1'b0;
                    gnt_r   <= ZERO_SRC;
                end
            endcase
        end
    end

    assign Ireq      = ireq_r;
    assign gntInt    = gnt_r;
    assign pending_o = pending_r;
    assign state_o   = state_r;

    assign unused_s = ^{int_en_i[31:NSRC], pick_full_s[31:NSRC]};

endmodule

// File: tb/tb_int_ctrl.sv
// Directed, table-driven bench for int_ctrl (NSRC=4, SYNC_STAGES=2, HOLD_CYC=4).
`timescale 1ns/100ps
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  int_src_i;
    logic [31:0] int_en_i;
    logic        Iack;
    logic        Ireq;
    logic [3:0]  gntInt;
    logic [3:0]  pending_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  src;
        logic [31:0] en;
        logic        iack;
        logic        ireq;
        logic [3:0]  gnt;
        logic [3:0]  pend;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[$];

    int_ctrl #(.NSRC(4), .SYNC_STAGES(2), .HOLD_CYC(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .int_src_i (int_src_i),
        .int_en_i  (int_en_i),
        .Iack      (Iack),
        .Ireq      (Ireq),
        .gntInt    (gntInt),
        .pending_o (pending_o),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic add(input string n, input logic [3:0] s, input logic [31:0] e, input logic a,
                       input logic r, input logic [3:0] g, input logic [3:0] p, input logic [1:0] st);
        vec_t v;
        v.name = n; v.src = s; v.en = e; v.iack = a;
        v.ireq = r; v.gnt = g; v.pend = p; v.st = st;
        vecs.push_back(v);
    endtask

    task automatic chk(input string n, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got ireq/gnt/pend/state=%b required %b", n, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] s, input logic [31:0] e, input logic a);
        int_src_i = s;
        int_en_i  = e;
        Iack      = a;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [10:0] pack(input logic r, input logic [3:0] g, input logic [3:0] p,
                                         input logic [1:0] st);
        return {r, g, p, st};
    endfunction

    initial begin
        logic [31:0] en_all;
        bit          done;
        en_all    = 32'h0000_000F;
        reset_n   = 1'b0;
        int_src_i = 4'b0000;
        int_en_i  = 32'h0000_0000;
        Iack      = 1'b0;

        // single source on bit 2
        add("single1", 4'b0100, en_all, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0);
        add("single2", 4'b0100, en_all, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0);
        add("single3", 4'b0000, en_all, 1'b0, 1'b0, 4'b0000, 4'b0100, 2'd0);
        add("single4", 4'b0000, en_all, 1'b0, 1'b1, 4'b0100, 4'b0100, 2'd1);
        add("single5", 4'b0000, en_all, 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd2);
        add("single6", 4'b0000, en_all, 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd2);
        for (int i = 0; i < 4; i++)
            add("single_hold", 4'b0000, en_all, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd3);
        add("single_idle", 4'b0000, en_all, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0);

        // priority: sources 3 and 1 together
        add("prio1", 4'b1010, en_all, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0);
        add("prio2", 4'b1010, en_all, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0);
        add("prio3", 4'b0000, en_all, 1'b0, 1'b0, 4'b0000, 4'b1010, 2'd0);
        add("prio4", 4'b0000, en_all, 1'b0, 1'b1, 4'b0010, 4'b1010, 2'd1);
        add("prio5", 4'b0000, en_all, 1'b1, 1'b0, 4'b0000, 4'b1000, 2'd2);
        for (int i = 0; i < 4; i++)
            add("prio_hold", 4'b0000, en_all, 1'b0, 1'b0, 4'b0000, 4'b1000, 2'd3);
        add("prio_idle", 4'b0000, en_all, 1'b0, 1'b0, 4'b0000, 4'b1000, 2'd0);
        add("prio_req2", 4'b0000, en_all, 1'b0, 1'b1, 4'b1000, 4'b1000, 2'd1);
        add("prio_ack2", 4'b0000, en_all, 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd2);
        for (int i = 0; i < 4; i++)
            add("prio_hold2", 4'b0000, en_all, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd3);
        add("prio_idle2", 4'b0000, en_all, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0);

        // masking on source 0
        add("mask1", 4'b0001, 32'h0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0);
        add("mask2", 4'b0001, 32'h0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0);
        add("mask3", 4'b0000, 32'h0, 1'b0, 1'b0, 4'b0000, 4'b0001, 2'd0);
        add("mask4", 4'b0000, 32'h0, 1'b0, 1'b0, 4'b0000, 4'b0001, 2'd0);
        add("mask_en", 4'b0000, 32'h1, 1'b0, 1'b1, 4'b0001, 4'b0001, 2'd1);
        add("mask_drop", 4'b0000, 32'h0, 1'b0, 1'b0, 4'b0000, 4'b0001, 2'd0);
        add("mask_off", 4'b0000, 32'h0, 1'b0, 1'b0, 4'b0000, 4'b0001, 2'd0);
        add("mask_reen", 4'b0000, 32'h1, 1'b0, 1'b1, 4'b0001, 4'b0001, 2'd1);
        add("mask_ack", 4'b0000, 32'h1, 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd2);
        for (int i = 0; i < 4; i++)
            add("mask_hold", 4'b0000, 32'h1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd3);
        add("mask_idle", 4'b0000, 32'h1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0);

        // set/clear collision on source 1
        add("coll1", 4'b0010, en_all, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0);
        add("coll2", 4'b0010, en_all, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0);
        add("coll3", 4'b0000, en_all, 1'b0, 1'b0, 4'b0000, 4'b0010, 2'd0);
        add("coll4", 4'b0000, en_all, 1'b0, 1'b1, 4'b0010, 4'b0010, 2'd1);
        add("coll5", 4'b0010, en_all, 1'b0, 1'b1, 4'b0010, 4'b0010, 2'd1);
        add("coll6", 4'b0000, en_all, 1'b0, 1'b1, 4'b0010, 4'b0010, 2'd1);
        add("coll_ack", 4'b0000, en_all, 1'b1, 1'b0, 4'b0000, 4'b0010, 2'd2);
        for (int i = 0; i < 4; i++)
            add("coll_hold", 4'b0000, en_all, 1'b0, 1'b0, 4'b0000, 4'b0010, 2'd3);
        add("coll_idle", 4'b0000, en_all, 1'b0, 1'b0, 4'b0000, 4'b0010, 2'd0);
        add("coll_rereq", 4'b0000, en_all, 1'b0, 1'b1, 4'b0010, 4'b0010, 2'd1);
        add("coll_ack2", 4'b0000, en_all, 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd2);
        for (int i = 0; i < 4; i++)
            add("coll_hold2", 4'b0000, en_all, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd3);
        add("coll_idle2", 4'b0000, en_all, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0);

        @(negedge clk);
        @(negedge clk);
        chk("reset_state", pack(Ireq, gntInt, pending_o, state_o), 11'd0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) begin
            step(vecs[k].src, vecs[k].en, vecs[k].iack);
            chk(vecs[k].name, pack(Ireq, gntInt, pending_o, state_o),
                pack(vecs[k].ireq, vecs[k].gnt, vecs[k].pend, vecs[k].st));
        end

        // reset asserted for 1 ns while a request is outstanding
        step(4'b0001, en_all, 1'b0);
        step(4'b0001, en_all, 1'b0);
        step(4'b0000, en_all, 1'b0);
        step(4'b0000, en_all, 1'b0);
        chk("rst_pre_req", pack(Ireq, gntInt, pending_o, state_o),
            pack(1'b1, 4'b0001, 4'b0001, 2'd1));
        #2;
        reset_n = 1'b0;
        #0.5;
        chk("rst_immediate", pack(Ireq, gntInt, pending_o, state_o), 11'd0);
        #0.5;
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) step(4'b0000, en_all, 1'b0);
        chk("rst_no_rereq", pack(Ireq, gntInt, pending_o, state_o), 11'd0);

        // grant src 3, then a higher-priority edge on src 0 arrives during REQ
        step(4'b1000, en_all, 1'b0);
        step(4'b1000, en_all, 1'b0);
        step(4'b0000, en_all, 1'b0);
        step(4'b0000, en_all, 1'b0);
        chk("rearb_req3", pack(Ireq, gntInt, pending_o, state_o),
            pack(1'b1, 4'b1000, 4'b1000, 2'd1));
        step(4'b0001, en_all, 1'b0);
        step(4'b0001, en_all, 1'b0);
        step(4'b0000, en_all, 1'b0);
        chk("rearb_pend", pack(Ireq, gntInt, pending_o, state_o),
            pack(1'b1, 4'b1000, 4'b1001, 2'd1));
        step(4'b0000, en_all, 1'b0);
`ifdef INTC_REARB_EN
        chk("rearb_drop", pack(Ireq, gntInt, pending_o, state_o),
            pack(1'b0, 4'b0000, 4'b1001, 2'd0));
        step(4'b0000, en_all, 1'b0);
        chk("rearb_new", pack(Ireq, gntInt, pending_o, state_o),
            pack(1'b1, 4'b0001, 4'b1001, 2'd1));
`else
        chk("rearb_fixed1", pack(Ireq, gntInt, pending_o, state_o),
            pack(1'b1, 4'b1000, 4'b1001, 2'd1));
        step(4'b0000, en_all, 1'b0);
        chk("rearb_fixed2", pack(Ireq, gntInt, pending_o, state_o),
            pack(1'b1, 4'b1000, 4'b1001, 2'd1));
`endif

        // drain: acknowledge every request until nothing is pending
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (Ireq) begin
                step(4'b0000, en_all, 1'b1);
            end else begin
                step(4'b0000, en_all, 1'b0);
            end
            done = (pending_o == 4'b0000) && (state_o == 2'd0);
        end
        chk("drain_done", pack(Ireq, gntInt, pending_o, state_o), 11'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller that sits at the far end of the CPU's interrupt handshake: it drives Ireq and a one-hot gntInt[3:0] into the CPU and consumes the CPU's Iack pulse.
- Synchronises up to NSRC asynchronous peripheral interrupt lines and latches rising edges as pending bits.
- Masks pending bits with the CPU's exported enable word, selects one source by fixed priority and holds the request until the CPU acknowledges it.
- Placed at SoC top level between peripherals and the multi-cycle CPU.

Parameters:
NSRC, 4, number of interrupt sources; must equal the CPU gntInt width.
SYNC_STAGES, 2, flip-flop stages per source synchroniser (>=2).
HOLD_CYC, 4, idle cycles after Iack deassertion before re-arbitration (>=1).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
int_src_i  in  NSRC  raw peripheral interrupt lines, asynchronous, rising-edge events.
int_en_i  in  32  CPU interrupt-enable word; bit i (i<NSRC) enables source i; other bits ignored.
Iack  in  1  CPU acknowledge; level, may be held several cycles.
Ireq  out  1  interrupt request to CPU.
gntInt  out  NSRC  one-hot granted source; valid only while Ireq=1.
pending_o  out  NSRC  pending register, unmasked, for status/debug.
state_o  out  2  current FSM state encoding.

Behaviour:
- Reset (async, reset_n=0): synchronisers, edge history and pending cleared. Ireq=0, gntInt=0, pending_o=0, state=IDLE, hold counter=0. Reset mid-request drops Ireq in the same instant and discards the grant.
- Synchroniser: SYNC_STAGES flops per bit, plus one history flop.
  - edge_i = sync_i & ~hist_i.
  - pending[i] sets on the clock after edge_i.
  - With SYNC_STAGES=2, pending_o rises on the 3rd rising edge that samples the input high.
- pending[i] clears only on acknowledge of source i. If a new edge on i coincides with its clear, set wins and the event is not lost.
- eligible = pending & int_en_i[NSRC-1:0].
- Priority: lowest index wins (bit 0 highest).
- FSM states: IDLE=0, REQ=1, SERV=2, HOLD=3.
  - IDLE: if eligible != 0, register the grant as the one-hot of the highest-priority eligible bit, set Ireq=1 and go to REQ. Ireq and gntInt are registered, 1 cycle after pending. Iack in IDLE is ignored.
  - REQ:
    - Ireq=1; gntInt is stable throughout REQ because the CPU samples it each cycle.
    - If Iack=1: clear pending of the granted bit, Ireq=0, gntInt=0, go to SERV.
    - Else if the granted source's enable bit drops to 0: withdraw (Ireq=0, gntInt=0, pending kept) and go to IDLE.
    - Iack takes precedence over a simultaneous mask drop.
  - SERV: wait while Iack=1. When Iack=0, load counter with HOLD_CYC-1 and go to HOLD.
  - HOLD: decrement each cycle. At 0 go to IDLE. No request in HOLD, even if eligible.
- Back-to-back: after a minimum of 1 SERV cycle + HOLD_CYC cycles, the next eligible source is requested.
- Ireq=0 implies gntInt=0. gntInt is never multi-hot.
- New edges on any source are captured in every state.

Optional Feature:
INTC_REARB_EN
- Defined: in REQ without Iack, if an eligible source of strictly higher priority than the current grant appears, drop Ireq/gntInt for exactly one cycle (passing through IDLE), then re-request with the new grant. The old source stays pending.
- Undefined: the grant is fixed until Iack or the mask drop.

Decomposition:
- Package intc_pkg holds:
  - state enum: IDLE, REQ, SERV, HOLD.
  - NSRC_DEF=4.
  - a priority-encode function (one-hot of lowest set bit).
- Sub-module intc_edge_sync: per-bit synchroniser plus edge detector, parameterised by SYNC_STAGES. The top instantiates it NSRC-wide.

Test Plan:
- Reset mid-REQ: reset_n low for 1 ns while Ireq=1 -> Ireq=0, gntInt=0, pending_o=0, state_o=0 immediately; no request after release until a new edge.
- Single source: int_en_i=32'h0000000F, pulse int_src_i[2] -> pending_o=4'b0100 on edge 3, Ireq=1/gntInt=4'b0100 on edge 4; Iack 2 cycles -> pending_o=0, Ireq=0, state returns to IDLE 1+HOLD_CYC cycles after Iack falls.
- Priority: edges on sources 3 and 1 in the same cycle -> gntInt=4'b0010 first; after Iack+HOLD, gntInt=4'b1000.
- Masking: int_en_i=0, edge on src 0 -> pending_o=4'b0001, Ireq stays 0; set int_en_i=1 -> Ireq=1 next cycle; clear enable during REQ -> Ireq=0, pending kept.
- Set/clear collision: new edge on src 1 in the same cycle Iack clears it -> pending_o[1] remains 1; re-requested after HOLD.
- With INTC_REARB_EN: in REQ granting src 3, edge on src 0 -> one cycle Ireq=0, then gntInt=4'b0001; without the macro, gntInt stays 4'b1000 until Iack.
